// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: ALU opcodes, FSM states and
// the command-word width helper used to size the FIFO payload.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  localparam int OP_W    = 2;
  localparam int OPS_W   = 16;

  // Bits in one packed {op, a, b, tag} command word.
  function automatic int cmd_w(input int width, input int tag_w);
    return OP_W + 2 * width + tag_w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter register.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  // A write on full is dropped even if the head leaves in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, drives one at a time onto the ALU control/operand
// registers, and returns the captured result/carry with the command tag.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [1:0]       cntrl_alu_o,
  output logic [WIDTH-1:0] reg_a_o,
  output logic [WIDTH-1:0] reg_b_o,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic [OPS_W-1:0] ops_done_o
);
  typedef struct packed {
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  localparam int CW = cmd_w(WIDTH, TAG_W);

  cmd_t                  in_cmd, head;
  logic [CW-1:0]         fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count;

  seq_state_e            state_q, state_d;
  logic                  cap, handoff;

  alu_op_e               cntrl_q;
  logic [WIDTH-1:0]      a_q, b_q, rsp_result_q;
  logic [TAG_W-1:0]      tag_q, rsp_tag_q;
  logic                  rsp_valid_q, rsp_carry_q;
  logic [OPS_W-1:0]      ops_done_q;

  assign in_cmd.op  = alu_op_e'(cmd_op_i);
  assign in_cmd.a   = cmd_a_i;
  assign in_cmd.b   = cmd_b_i;
  assign in_cmd.tag = cmd_tag_i;
  assign head       = cmd_t'(fifo_rdata);

  alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (cmd_valid_i),
    .pop   (fifo_pop),
    .wdata (in_cmd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A completed handoff chains straight into the next pop, giving one
  // response every two cycles under continuous consumption.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    cap      = 1'b0;
    handoff  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cap     = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          handoff = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU-side registers only move on a pop; they hold while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cntrl_q <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else if (fifo_pop) begin
      cntrl_q <= head.op;
      a_q     <= head.a;
      b_q     <= head.b;
      tag_q   <= head.tag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_tag_q    <= '0;
    end else if (cap) begin
      rsp_valid_q  <= 1'b1;
      rsp_result_q <= result_i;
      rsp_carry_q  <= carry_i;
      rsp_tag_q    <= tag_q;
    end else if (handoff) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      ops_done_q <= '0;
    else if (handoff) ops_done_q <= ops_done_q + 1'b1;
  end

  assign cmd_ready_o  = !fifo_full;
  assign cntrl_alu_o  = cntrl_q;
  assign reg_a_o      = a_q;
  assign reg_b_o      = b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign busy_o       = (fifo_count != '0) || (state_q != IDLE);
  assign ops_done_o   = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU on the
// operand/control lines.
module tb_alu_op_sequencer;
  logic        clk, rst_ni;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [1:0]  cntrl_alu;
  logic [7:0]  reg_a, reg_b, result;
  logic        carry;
  logic        rsp_valid, rsp_ready, rsp_carry, busy;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_tag;
  logic [15:0] ops_done;

  int n_chk = 0;
  int n_pass = 0;
  logic [12:0] sb [$];

  alu_op_sequencer #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_tag_i(cmd_tag),
    .cntrl_alu_o(cntrl_alu), .reg_a_o(reg_a), .reg_b_o(reg_b),
    .result_i(result), .carry_i(carry),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_carry_o(rsp_carry), .rsp_tag_o(rsp_tag),
    .busy_o(busy), .ops_done_o(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {result, carry, tag}; carry is bit 8 of the 9-bit sum/difference.
  function automatic logic [12:0] model(input logic [1:0] op, input logic [7:0] a, b,
                                        input logic [3:0] tag);
    logic [8:0] r;
    case (op)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {1'b0, a} - {1'b0, b};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return {r[7:0], r[8], tag};
  endfunction

  logic [12:0] alu_out;
  assign alu_out = model(cntrl_alu, reg_a, reg_b, 4'd0);
  assign result  = alu_out[12:5];
  assign carry   = alu_out[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Inputs only change at posedge+2, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (cmd_valid && cmd_ready) sb.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else chk("sb_rsp", {rsp_result, rsp_carry, rsp_tag}, sb.pop_front());
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] a, b, input logic [3:0] tag);
    bit ok = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic single_op(input logic [1:0] op, input logic [7:0] a, b, input logic [3:0] tag,
                           input logic [7:0] er, input logic ec);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    @(posedge clk); #2 cmd_valid = 1'b0;
    @(negedge clk); chk("lat_n0", rsp_valid, 1'b0);
    @(negedge clk); chk("lat_n1", rsp_valid, 1'b0);
    @(negedge clk); chk("lat_n2", rsp_valid, 1'b1);
    chk("op_rsp", {rsp_result, rsp_carry, rsp_tag}, {er, ec, tag});
    @(posedge clk); #2;
  endtask

  task automatic drain(input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
  endtask

  initial begin
    logic [12:0] snap;
    bit ok;
    rst_ni = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu", {cntrl_alu, reg_a, reg_b}, 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_carry, rsp_tag}, 32'd0);
    chk("rst_ops", ops_done, 16'd0);
    @(posedge clk); #2;

    single_op(2'd0, 8'hFF, 8'h01, 4'd3, 8'h00, 1'b1);
    single_op(2'd1, 8'h05, 8'h07, 4'd4, 8'hFE, 1'b1);
    single_op(2'd2, 8'hF0, 8'h3C, 4'd5, 8'h30, 1'b0);
    single_op(2'd3, 8'hA0, 8'h0A, 4'd6, 8'hAA, 1'b0);
    chk("ops_single", ops_done, 16'd4);

    // Fill: one issued plus four queued, then a held-off sixth offer.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'(i), 8'(i * 17 + 3), 8'(i + 1), 4'(i));
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_ready", cmd_ready, 1'b0);
    chk("full_count", dut.u_fifo.count, 3'd4);
    chk("bp_valid", rsp_valid, 1'b1);
    snap = {rsp_result, rsp_carry, rsp_tag};
    @(posedge clk); #2;
    cmd_op = 2'd1; cmd_a = 8'h10; cmd_b = 8'h20; cmd_tag = 4'd5; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", {rsp_valid, rsp_result, rsp_carry, rsp_tag}, {1'b1, snap});
      chk("hold_ready", cmd_ready, 1'b0);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("sixth_timeout", 32'd0, 32'd1);
    @(posedge clk); #2 cmd_valid = 1'b0;
    drain(100);
    chk("ops_fill", ops_done, 16'd6);

    // Push and pop on the same edge with two entries queued.
    rsp_ready = 1'b0;
    push(2'd0, 8'h11, 8'h22, 4'd8);
    push(2'd1, 8'h01, 8'h02, 4'd9);
    push(2'd2, 8'hCC, 8'h0F, 4'd10);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_pre", dut.u_fifo.count, 3'd2);
    chk("pp_resp", rsp_valid, 1'b1);
    @(posedge clk); #2 rsp_ready = 1'b1;
    push(2'd3, 8'h40, 8'h04, 4'd11);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_post", dut.u_fifo.count, 3'd2);
    @(posedge clk); #2;
    drain(100);
    chk("ops_pp", ops_done, 16'd10);

    // Reset while a response is waiting and another command is queued.
    rsp_ready = 1'b0;
    push(2'd0, 8'h01, 8'h01, 4'd1);
    push(2'd0, 8'h02, 8'h02, 4'd2);
    cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("mid_valid", ok, 1'b1);
    #1 rst_ni = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_ops", ops_done, 16'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    @(posedge clk); @(posedge clk); #2 rst_ni = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, busy}, 2'b00);
    end
    @(posedge clk); #2;

    // Counter wrap from a preloaded 0xFFFF.
    force dut.ops_done_q = 16'hFFFF;
    #1 release dut.ops_done_q;
    @(negedge clk);
    chk("pre_wrap", ops_done, 16'hFFFF);
    @(posedge clk); #2;
    single_op(2'd0, 8'h01, 8'h02, 4'hC, 8'h03, 1'b0);
    @(negedge clk);
    chk("wrap", ops_done, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for the team's combinational ALU block. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time on the ALU control and operand lines, captures the result and carry, and returns them with the command's tag over a valid/ready response interface. It sits between a bus or test-driver master and the ALU instance.

Parameters:
WIDTH, 8, operand/result width; must match the ALU instance.
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the opaque command tag echoed in the response.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
cmd_valid_i  in  1  command offered.
cmd_ready_o  out  1  FIFO can accept; equals !full.
cmd_op_i  in  2  0 ADD, 1 SUB, 2 AND, 3 OR.
cmd_a_i  in  WIDTH  operand A.
cmd_b_i  in  WIDTH  operand B.
cmd_tag_i  in  TAG_W  command tag.
cntrl_alu_o  out  2  ALU operation select.
reg_a_o  out  WIDTH  ALU operand A (registered).
reg_b_o  out  WIDTH  ALU operand B (registered).
result_i  in  WIDTH  ALU result.
carry_i  in  1  ALU carry/borrow (bit WIDTH of ALU internal sum).
rsp_valid_o  out  1  response available.
rsp_ready_i  in  1  response consumer ready.
rsp_result_o  out  WIDTH  captured result.
rsp_carry_o  out  1  captured carry.
rsp_tag_o  out  TAG_W  tag of the completed command.
busy_o  out  1  high when FIFO non-empty or state != IDLE.
ops_done_o  out  16  count of responses handed off; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async assert, sync release): FIFO empty; state IDLE; all outputs 0, except cmd_ready_o = 1.
- Push: on an edge where cmd_valid_i && cmd_ready_o, the command is written to the FIFO tail.
- Full FIFO: cmd_ready_o = 0 and no write occurs. There is no push-through on full, even if a pop happens in the same cycle.
- Push and pop in the same cycle with the FIFO not full: both take effect; count is unchanged.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if the FIFO is non-empty, pop the head and load op/a/b into the cntrl_alu_o/reg_a_o/reg_b_o registers; hold the tag internally; go to ISSUE. If empty, stay in IDLE.
- ISSUE: one full cycle for the ALU to settle. At the edge, capture result_i, carry_i and the tag into the rsp registers; rsp_valid_o goes to 1; go to RESP.
- RESP: hold all rsp_* outputs stable while rsp_valid_o && !rsp_ready_i.
- RESP with rsp_ready_i = 1: handoff; ops_done_o increments.
  - FIFO non-empty: pop the next command, load the ALU registers, go to ISSUE; rsp_valid_o drops to 0.
  - FIFO empty: go to IDLE; rsp_valid_o drops to 0.
- Latency: a command accepted at edge N into an empty, idle block gives rsp_valid_o = 1 after edge N+2.
- Throughput: one response per 2 cycles when rsp_ready_i is held at 1.
- The ALU registers hold their last values while idle; they change only on a pop.
- The block does no arithmetic of its own; result and carry are passed through unmodified. SUB borrow appears as carry = 1.
- rsp_valid_o never depends combinationally on rsp_ready_i.
- Reset mid-operation: the in-flight command and all buffered commands are discarded; no response is produced; ops_done_o returns to 0.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_e enum (ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_OR=2'd3);
  - seq_state_e enum (IDLE, ISSUE, RESP);
  - a parameterised command struct type or a packing function for {op, a, b, tag}.
- One sub-module, alu_cmd_fifo: synchronous FIFO with DEPTH entries, pointers of $clog2(DEPTH)+1 bits, and full/empty/count outputs, using the same clock and reset.

Test Plan:
- Reset check: after reset release, all outputs 0, cmd_ready_o = 1, busy_o = 0. Assert rst_ni low during RESP -> rsp_valid_o drops immediately and ops_done_o = 0.
- Single ops, WIDTH=8, rsp_ready_i = 1, with rsp_valid_o exactly 2 edges after acceptance in each case:
  - ADD 0xFF+0x01, tag 3 -> result 0x00, carry 1, tag 3.
  - SUB 0x05-0x07 -> result 0xFE, carry 1.
  - AND 0xF0&0x3C -> 0x30, carry 0.
  - OR 0xA0|0x0A -> 0xAA, carry 0.
- Fill FIFO: push 5 commands back-to-back with rsp_ready_i = 0 -> 4 are queued plus 1 issued. cmd_ready_o falls after the 5th acceptance, and a 6th offer is held off until the next pop.
- Backpressure: hold rsp_ready_i = 0 for 10 cycles in RESP -> rsp_* stable. On release, responses arrive in FIFO order with tags 0..4, and ops_done_o = 5.
- Simultaneous push and pop at count 2 -> count stays 2 and the ordering is preserved.
- Counter wrap: preload 0xFFFF responses (or force ops_done_o), complete one more op -> ops_done_o = 0x0000.
